// File: rtl/add128_seq.sv
// add128_seq: multi-cycle W-bit adder that reuses one CHUNK-bit adder slice.
// It latches both operands, adds one chunk per cycle from LSB to MSB with a
// registered inter-chunk carry, and then holds the result behind a valid/ready
// handshake.
//
// Optional feature macro: ADD128_SUB_EN. When it is defined, the `sub` port
// exists and requests A - B - cin in two's complement.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operands present
//   in_ready   out  idle and able to accept
//   a, b       in   W-bit operands
//   cin        in   carry into bit 0
//   sub        in   (ADD128_SUB_EN only) subtract request
//   out_valid  out  result held
//   out_ready  in   consumer takes result
//   s          out  W-bit sum
//   cout       out  carry out of bit W-1
//   busy       out  operation in RUN or DONE
module add128_seq #(
   parameter int unsigned W     = 128,
   parameter int unsigned CHUNK = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
`ifdef ADD128_SUB_EN
   input  logic         sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         busy
);

   localparam int unsigned BEATS  = (W + CHUNK - 1) / CHUNK;
   localparam int unsigned LAST_W = W - (BEATS - 1) * CHUNK;
   localparam int unsigned KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LAST_W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state;
   logic [KW-1:0]  k;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           carry;

   logic [W-1:0]   b_eff;
   logic           cin_eff;
   logic [31:0]    shift;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic [CHUNK-1:0] chunk_bits;
   logic           last_beat;
   logic           carry_next;
   logic [W-1:0]   s_next;

   // Operand conditioning at acceptance: subtraction adds ~B with inverted carry-in.
   always_comb begin
      b_eff   = b;
      cin_eff = cin;
`ifdef ADD128_SUB_EN
      if (sub) begin
         b_eff   = ~b;
         cin_eff = ~cin;
      end
`endif
   end

   // One beat of the shared slice. The latched operands have zeros above bit
   // W-1, so the final narrow beat sees zero-extended chunks and its carry
   // must be picked from bit LAST_W rather than bit CHUNK.
   always_comb begin
      shift      = 32'(k) * CHUNK;
      a_chunk    = CHUNK'(a_q >> shift);
      b_chunk    = CHUNK'(b_q >> shift);
      chunk_sum  = (CHUNK+1)'(a_chunk) + (CHUNK+1)'(b_chunk) + (CHUNK+1)'(carry);
      last_beat  = (k == KW'(BEATS - 1));
      carry_next = last_beat ? chunk_sum[LAST_W] : chunk_sum[CHUNK];
      chunk_bits = last_beat ? (chunk_sum[CHUNK-1:0] & LAST_MASK) : chunk_sum[CHUNK-1:0];
      // s is cleared at acceptance, so OR-ing the new chunk in places it.
      s_next     = s | (W'(chunk_bits) << shift);
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         a_q       <= '0;
         b_q       <= '0;
         carry     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_q      <= a;
                  b_q      <= b_eff;
                  carry    <= cin_eff;
                  k        <= '0;
                  s        <= '0;
                  cout     <= 1'b0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               s     <= s_next;
               carry <= carry_next;
               if (last_beat) begin
                  k         <= '0;
                  cout      <= carry_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  k <= k + KW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add128_seq.sv
// Self-checking bench for add128_seq: randomized operands checked against a
// plain-arithmetic reference, plus directed carry, hold, reset and
// back-to-back scenarios.
module tb_add128_seq;

   localparam int unsigned W     = 128;
   localparam int unsigned CHUNK = 24;
   localparam int unsigned BEATS = (W + CHUNK - 1) / CHUNK;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         cout;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   add128_seq #(.W(W), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef ADD128_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .busy      (busy)
   );

   // Reference: {cout,s} = a + b + cin; subtraction gives a - b - cin with cout = no borrow.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input logic sb);
      logic [W:0] r;
      if (sb) begin
         r    = {1'b0, x} - {1'b0, y} - (W+1)'(c);
         r[W] = ~r[W];
      end else begin
         r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Drive one full transaction; returns result and cycles from acceptance to out_valid.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic sb, output logic [W-1:0] so, output logic co,
                         output int lat);
      int w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      a = x; b = y; cin = c; sub = sb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = rand128(); b = rand128(); cin = 1'($urandom_range(0, 1));
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      so = s; co = cout;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (s !== '0) $display("FAIL reset_s got %h want 0", s); else n_pass++;
      n_checks++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else n_pass++;
   endtask

   task automatic test_directed();
      logic [W-1:0] va[3];
      logic [W-1:0] vb[3];
      logic         vc[3];
      logic [W-1:0] es[3];
      logic         ec[3];
      logic [W-1:0] so;
      logic         co;
      int           lat;
      va[0] = '1;                   vb[0] = '0;                   vc[0] = 1'b1;
      es[0] = '0;                   ec[0] = 1'b1;
      va[1] = W'(24'hFF_FFFF);      vb[1] = W'(1);                vc[1] = 1'b0;
      es[1] = W'(32'h0100_0000);    ec[1] = 1'b0;
      va[2] = {8'hFF, 120'h0};      vb[2] = {8'h01, 120'h0};      vc[2] = 1'b0;
      es[2] = '0;                   ec[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], vc[i], 1'b0, so, co, lat);
         n_checks++; if (lat != int'(BEATS)) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, BEATS); else n_pass++;
         n_checks++; if (so !== es[i]) $display("FAIL dir%0d_s got %h want %h", i, so, es[i]); else n_pass++;
         n_checks++; if (co !== ec[i]) $display("FAIL dir%0d_cout got %b want %b", i, co, ec[i]); else n_pass++;
         n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL dir%0d_handshake in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, y, so;
      logic         c, co;
      logic [W:0]   e;
      int           lat;
      for (int i = 0; i < 20; i++) begin
         x = rand128(); y = rand128(); c = 1'($urandom_range(0, 1));
         if (i == 0) begin x = '1; y = '1; c = 1'b1; end
         e = model(x, y, c, 1'b0);
         run_op(x, y, c, 1'b0, so, co, lat);
         n_checks++; if ({co, so} !== e) $display("FAIL rand%0d_sum got %b_%h want %b_%h", i, co, so, e[W], e[W-1:0]); else n_pass++;
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] x, y;
      logic [W:0]   e;
      int           w = 0;
      x = rand128(); y = rand128();
      e = model(x, y, 1'b0, 1'b0);
      a = x; b = y; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      n_checks++; if (out_valid !== 1'b1) $display("FAIL hold_reach_done got %b want 1", out_valid); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         a = rand128(); b = rand128();
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || {cout, s} !== e || in_ready !== 1'b0)
            $display("FAIL hold%0d got ov=%b ir=%b %b_%h want ov=1 ir=0 %b_%h",
                     i, out_valid, in_ready, cout, s, e[W], e[W-1:0]);
         else n_pass++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL hold_release got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] so;
      logic         co;
      int           lat;
      a = rand128(); b = rand128(); cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL midrst_ctrl got ir=%b ov=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
      else n_pass++;
      n_checks++; if (s !== '0 || cout !== 1'b0) $display("FAIL midrst_result got %b_%h want 0_0", cout, s); else n_pass++;
      repeat (8) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_no_output got %b want 0", out_valid); else n_pass++;
      run_op(W'(5), W'(7), 1'b0, 1'b0, so, co, lat);
      n_checks++; if (so !== W'(12) || co !== 1'b0) $display("FAIL midrst_5p7 got %b_%h want 0_c", co, so); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [W:0] q[$];
      logic [W:0] e, obs;
      logic       acc, ov;
      int         last_acc = -1;
      int         n_acc = 0;
      int         n_out = 0;
      sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (cyc == 60) in_valid = 1'b0;
         a = rand128(); b = rand128(); cin = 1'($urandom_range(0, 1));
         acc = in_ready && in_valid;
         ov  = out_valid;
         obs = {cout, s};
         e   = model(a, b, cin, 1'b0);
         @(posedge clk); #1;
         if (acc) begin
            q.push_back(e);
            if (last_acc >= 0) begin
               n_checks++; if (cyc - last_acc != int'(BEATS) + 2)
                  $display("FAIL b2b_interval got %0d want %0d", cyc - last_acc, BEATS + 2);
               else n_pass++;
            end
            last_acc = cyc;
            n_acc++;
         end
         if (ov) begin
            n_out++;
            n_checks++;
            if (q.size() == 0) $display("FAIL b2b_spurious_output got %b_%h want none", obs[W], obs[W-1:0]);
            else begin
               e = q.pop_front();
               if (obs !== e) $display("FAIL b2b_result got %b_%h want %b_%h", obs[W], obs[W-1:0], e[W], e[W-1:0]);
               else n_pass++;
            end
         end
      end
      out_ready = 1'b0;
      n_checks++; if (n_acc != 8) $display("FAIL b2b_accept_count got %0d want 8", n_acc); else n_pass++;
      n_checks++; if (q.size() != 0 || n_out != n_acc)
         $display("FAIL b2b_drain got outputs=%0d pending=%0d want %0d/0", n_out, q.size(), n_acc);
      else n_pass++;
   endtask

`ifdef ADD128_SUB_EN
   task automatic test_sub();
      logic [W-1:0] so, x, y;
      logic         co, c;
      logic [W:0]   e;
      int           lat;
      run_op(W'(3), W'(5), 1'b0, 1'b1, so, co, lat);
      n_checks++; if (so !== {{(W-1){1'b1}}, 1'b0} || co !== 1'b0) $display("FAIL sub_3m5 got %b_%h want 0_fff..fe", co, so); else n_pass++;
      n_checks++; if (lat != int'(BEATS)) $display("FAIL sub_latency got %0d want %0d", lat, BEATS); else n_pass++;
      run_op(W'(5), W'(3), 1'b0, 1'b1, so, co, lat);
      n_checks++; if (so !== W'(2) || co !== 1'b1) $display("FAIL sub_5m3 got %b_%h want 1_2", co, so); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         x = rand128(); y = rand128(); c = 1'($urandom_range(0, 1));
         e = model(x, y, c, 1'b1);
         run_op(x, y, c, 1'b1, so, co, lat);
         n_checks++; if ({co, so} !== e) $display("FAIL sub_rand%0d got %b_%h want %b_%h", i, co, so, e[W], e[W-1:0]); else n_pass++;
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_reset_mid();
      test_back_to_back();
`ifdef ADD128_SUB_EN
      test_sub();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/add128_seq.md
# add128_seq

Multi-cycle 128-bit adder sequencer for the nroot datapath. It reuses a single 24-bit full-adder slice over successive cycles instead of a 128-bit ripple chain. It latches both operands, walks the word from LSB chunk to MSB chunk, and registers the inter-chunk carry between beats. It then presents the sum and carry-out behind a valid/ready handshake.

## Interface
- `W`, 128: operand/result width.
- `CHUNK`, 24: slice width per beat. `BEATS = ceil(W/CHUNK)` = 6 at defaults. The last beat is `W-(BEATS-1)*CHUNK` bits wide (8 at defaults).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block idle and able to accept.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `cin`  in  1  carry into bit 0. It is honoured, not tied low.
- `sub`  in  1  present only with `ADD128_SUB_EN`: request A−B.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `s`  out  W  sum.
- `cout`  out  1  carry out of bit W−1.
- `busy`  out  1  high in RUN or DONE.

## Operation
- States are IDLE, RUN and DONE.
- In IDLE, `in_ready`=1.
  - On `in_valid & in_ready`, latch `a`, `b` and the effective carry-in into the carry register.
  - Clear beat counter `k`=0 and the result register, then go to RUN.
- In RUN, each cycle adds chunk `k` of A, chunk `k` of B and the carry register.
  - Write the chunk sum into `s[k*CHUNK +: width_k]` and the chunk carry into the carry register.
  - Increment `k`.
  - After beat `BEATS-1`, the carry register holds `cout`; go to DONE.
- The final beat uses only the low `width_k` bits. Its carry is taken at bit `width_k-1`, never at bit CHUNK−1.
- In DONE, `out_valid`=1, and `s`/`cout` are stable.
  - On `out_ready`, return to IDLE.
  - `out_valid` falls on the next edge.
- Only one operation is outstanding. `in_valid` is ignored outside IDLE, and operands need not be held after acceptance.
- Result arithmetic: `{cout,s}` = `a + b + cin` modulo 2^(W+1), unsigned. No overflow flag.
- `s` and `cout` keep their last value in IDLE until the next acceptance clears them.
- Reset values:
  - state IDLE, `k`=0.
  - `in_ready`=1 from the first cycle with `rst` low.
  - `out_valid`=0, `busy`=0, `s`=0, `cout`=0.
- Reset mid-operation (RUN or DONE) abandons the operation with no output. The block is back in IDLE with reset values on the edge where `rst` is sampled high.

## Timing
- Acceptance happens at edge E0.
- Beats are registered on edges E1..E_BEATS (E1..E6 at defaults).
- `out_valid` is high from the cycle after E_BEATS. That is exactly BEATS cycles after acceptance, with no combinational path from `in_valid` to `out_valid`.
- If `out_ready` is high on the first DONE cycle, the handshake completes at E_BEATS+1.
  - `in_ready` is high in the following cycle.
  - Minimum initiation interval is BEATS+2 cycles.
- `out_ready` low holds DONE indefinitely with outputs frozen.
- `in_ready` depends only on state, never combinationally on `out_ready`.
- `rst` has priority over every handshake on the same edge.

## Configuration
- `ADD128_SUB_EN` defined:
  - The `sub` port exists.
  - When `sub`=1 at acceptance, B is latched inverted and the effective carry-in is `~cin`. The result is A−B−cin in two's complement.
  - `cout`=1 means no borrow.
- Not defined:
  - There is no `sub` port.
  - B is latched as is and the effective carry-in is `cin`.
- Latency is identical in both builds.

## Test plan
- a=2^128−1, b=0, cin=1 -> after 6 cycles, `s`=0 and `cout`=1. The carry ripples through all 6 beats.
- a=0x…00FFFFFF (low 24 ones), b=1, cin=0 -> `s`=0x1000000 and `cout`=0. This checks the chunk-0 to chunk-1 carry hand-off.
- a=0xFF<<120, b=1<<120 -> `s`=0 and `cout`=1. This checks the 8-bit final beat, with its carry taken from bit 127.
- Random a/b with `out_ready` held low for 10 cycles -> `out_valid` stays 1 and `s`/`cout` are unchanged. `in_valid` pulses during the hold are not accepted; then one transfer completes.
- `rst` high at beat 3 -> the next cycle shows `in_ready`=1, `out_valid`=0 and `s`=0. A following add of 5+7 returns 12.
- With `ADD128_SUB_EN`: a=3, b=5, sub=1, cin=0 -> `s`=2^128−2 and `cout`=0. With a=5, b=3: `s`=2 and `cout`=1.
